// File: rtl/lbist_sequencer.sv
// LBIST run sequencer: drives TPG/filter resets and filter advance pulses through a
// multi-set self-test run, tracking a saturating error count and the first failing set.
module lbist_sequencer #(
    parameter int unsigned ERR_BITS    = 8,
    parameter int unsigned SET_BITS    = 4,
    parameter int unsigned SETUP_DELAY = 12,
    parameter int unsigned ERR_LIMIT   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                tpg_end,
    input  logic                ora_fail,
    input  logic                fil_end,
    output logic                tpg_reset,
    output logic                fil_reset,
    output logic                fil_inc,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                aborted,
    output logic [ERR_BITS-1:0] err_count,
    output logic [SET_BITS-1:0] set_idx,
    output logic [SET_BITS-1:0] first_fail_set,
    output logic                fail_seen
);

    localparam int unsigned CNT_BITS = (SETUP_DELAY > 1) ? $clog2(SETUP_DELAY) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(SETUP_DELAY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RUN,
        S_ADV,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                tpg_reset_q, tpg_reset_d;
    logic                fil_reset_q, fil_reset_d;
    logic                fil_inc_q, fil_inc_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                aborted_q, aborted_d;
    logic [ERR_BITS-1:0] err_q, err_d;
    logic [SET_BITS-1:0] set_q, set_d;
    logic [SET_BITS-1:0] ffs_q, ffs_d;
    logic                fail_seen_q, fail_seen_d;

    logic [ERR_BITS-1:0] err_sat;
    logic                limit_hit;
    logic                launch;

    // Shared decode: count after a failure, and whether that count trips the abort limit.
    always_comb begin
        err_sat   = (err_q == '1) ? err_q : err_q + 1'b1;
        limit_hit = (ERR_LIMIT != 0) && (32'(err_sat) >= ERR_LIMIT);
        launch    = start && (state_q == S_IDLE || state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tpg_reset_q <= 1'b1;
            fil_reset_q <= 1'b1;
            fil_inc_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            aborted_q   <= 1'b0;
            err_q       <= '0;
            set_q       <= '0;
            ffs_q       <= '0;
            fail_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tpg_reset_q <= tpg_reset_d;
            fil_reset_q <= fil_reset_d;
            fil_inc_q   <= fil_inc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            aborted_q   <= aborted_d;
            err_q       <= err_d;
            set_q       <= set_d;
            ffs_q       <= ffs_d;
            fail_seen_q <= fail_seen_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SETUP;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) state_d = S_RUN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_RUN: begin
                if (fil_end)       state_d = S_DONE;
                else if (ora_fail) state_d = limit_hit ? S_DONE : S_ADV;
                else if (tpg_end)  state_d = S_ADV;
            end
            S_ADV:   state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs are computed from the next state so they change on the same edge.
    always_comb begin
        err_d       = err_q;
        set_d       = set_q;
        ffs_d       = ffs_q;
        fail_seen_d = fail_seen_q;
        aborted_d   = aborted_q;

        if (launch) begin
            err_d       = '0;
            set_d       = '0;
            ffs_d       = '0;
            fail_seen_d = 1'b0;
            aborted_d   = 1'b0;
        end else if (state_q == S_RUN) begin
            if (ora_fail) begin
                err_d = err_sat;
                if (!fail_seen_q) begin
                    ffs_d       = set_q;
                    fail_seen_d = 1'b1;
                end
                if (!fil_end && limit_hit) aborted_d = 1'b1;
            end
            if (state_d == S_ADV && set_q != '1) set_d = set_q + 1'b1;
        end

        tpg_reset_d = 1'b1;
        fil_reset_d = 1'b0;
        fil_inc_d   = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        pass_d      = 1'b0;
        case (state_d)
            S_IDLE: fil_reset_d = 1'b1;
            S_SETUP: begin
                fil_reset_d = 1'b1;
                busy_d      = 1'b1;
            end
            S_RUN: begin
                tpg_reset_d = 1'b0;
                busy_d      = 1'b1;
            end
            S_ADV: begin
                tpg_reset_d = ora_fail;
                fil_inc_d   = 1'b1;
                busy_d      = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
                pass_d = (err_d == '0) && !aborted_d;
            end
            default: fil_reset_d = 1'b1;
        endcase
    end

    assign tpg_reset      = tpg_reset_q;
    assign fil_reset      = fil_reset_q;
    assign fil_inc        = fil_inc_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign aborted        = aborted_q;
    assign err_count      = err_q;
    assign set_idx        = set_q;
    assign first_fail_set = ffs_q;
    assign fail_seen      = fail_seen_q;

endmodule

// File: tb/tb_lbist_sequencer.sv
// Directed bench for lbist_sequencer: three instances share stimulus (default, ERR_LIMIT=3,
// ERR_BITS=2) so the abort and saturation variants are checked alongside the main flow.
module tb_lbist_sequencer;

    logic clk = 1'b0;
    logic rst_n, start, tpg_end, ora_fail, fil_end;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic       a_tpg_reset, a_fil_reset, a_fil_inc, a_busy, a_done, a_pass, a_aborted, a_fail_seen;
    logic [7:0] a_err;
    logic [3:0] a_set, a_ffs;
    logic       b_tpg_reset, b_fil_reset, b_fil_inc, b_busy, b_done, b_pass, b_aborted, b_fail_seen;
    logic [7:0] b_err;
    logic [3:0] b_set, b_ffs;
    logic       c_tpg_reset, c_fil_reset, c_fil_inc, c_busy, c_done, c_pass, c_aborted, c_fail_seen;
    logic [1:0] c_err;
    logic [3:0] c_set, c_ffs;

    lbist_sequencer u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .tpg_end(tpg_end), .ora_fail(ora_fail),
        .fil_end(fil_end), .tpg_reset(a_tpg_reset), .fil_reset(a_fil_reset), .fil_inc(a_fil_inc),
        .busy(a_busy), .done(a_done), .pass(a_pass), .aborted(a_aborted), .err_count(a_err),
        .set_idx(a_set), .first_fail_set(a_ffs), .fail_seen(a_fail_seen)
    );

    lbist_sequencer #(.ERR_LIMIT(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .tpg_end(tpg_end), .ora_fail(ora_fail),
        .fil_end(fil_end), .tpg_reset(b_tpg_reset), .fil_reset(b_fil_reset), .fil_inc(b_fil_inc),
        .busy(b_busy), .done(b_done), .pass(b_pass), .aborted(b_aborted), .err_count(b_err),
        .set_idx(b_set), .first_fail_set(b_ffs), .fail_seen(b_fail_seen)
    );

    lbist_sequencer #(.ERR_BITS(2), .ERR_LIMIT(0)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start), .tpg_end(tpg_end), .ora_fail(ora_fail),
        .fil_end(fil_end), .tpg_reset(c_tpg_reset), .fil_reset(c_fil_reset), .fil_inc(c_fil_inc),
        .busy(c_busy), .done(c_done), .pass(c_pass), .aborted(c_aborted), .err_count(c_err),
        .set_idx(c_set), .first_fail_set(c_ffs), .fail_seen(c_fail_seen)
    );

    // Present one event for a single sampling edge; returns at the following negedge.
    task automatic ev(input logic t, input logic f, input logic e);
        tpg_end = t; ora_fail = f; fil_end = e;
        @(negedge clk);
        tpg_end = 1'b0; ora_fail = 1'b0; fil_end = 1'b0;
    endtask

    // Start a run from IDLE/DONE and verify the setup window length and cleared results.
    task automatic start_run(input string tag);
        int hi;
        hi = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (a_tpg_reset === 1'b1 && a_fil_reset === 1'b1 && a_busy === 1'b1) hi++;
            @(negedge clk);
        end
        checks++;
        if (hi !== 12) begin
            errors++; $display("FAIL %s_setup_len: got %0d cycles, expected 12", tag, hi);
        end
        checks++;
        if ({a_tpg_reset, a_fil_reset, a_busy} !== 3'b001) begin
            errors++; $display("FAIL %s_run_entry: got tpg/fil/busy=%b, expected 001", tag,
                               {a_tpg_reset, a_fil_reset, a_busy});
        end
        checks++;
        if ({a_err, a_set, a_ffs, a_fail_seen, a_aborted, a_done} !== 19'd0) begin
            errors++; $display("FAIL %s_cleared: got err=%0d set=%0d ffs=%0d seen=%b ab=%b done=%b, expected all 0",
                               tag, a_err, a_set, a_ffs, a_fail_seen, a_aborted, a_done);
        end
    endtask

    // One advance from RUN: checks the ADV cycle and the return to RUN.
    task automatic adv_step(input logic t, input logic f, input string tag);
        ev(t, f, 1'b0);
        checks++;
        if (a_fil_inc !== 1'b1 || a_tpg_reset !== f) begin
            errors++; $display("FAIL %s_adv: got fil_inc=%b tpg_reset=%b, expected 1 %b", tag, a_fil_inc, a_tpg_reset, f);
        end
        @(negedge clk);
        checks++;
        if ({a_fil_inc, a_tpg_reset, a_busy} !== 3'b001) begin
            errors++; $display("FAIL %s_back_run: got fil_inc/tpg/busy=%b, expected 001", tag,
                               {a_fil_inc, a_tpg_reset, a_busy});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; tpg_end = 1'b0; ora_fail = 1'b0; fil_end = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_tpg_reset, a_fil_reset, a_fil_inc, a_busy, a_done, a_pass, a_aborted, a_fail_seen} !== 8'b1100_0000 ||
            a_err !== 8'd0 || a_set !== 4'd0 || a_ffs !== 4'd0) begin
            errors++; $display("FAIL reset_values: got ctl=%b err=%0d set=%0d ffs=%0d, expected 11000000 0 0 0",
                               {a_tpg_reset, a_fil_reset, a_fil_inc, a_busy, a_done, a_pass, a_aborted, a_fail_seen},
                               a_err, a_set, a_ffs);
        end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({a_tpg_reset, a_fil_reset, a_busy, a_done} !== 4'b1100) begin
            errors++; $display("FAIL idle_hold: got tpg/fil/busy/done=%b, expected 1100",
                               {a_tpg_reset, a_fil_reset, a_busy, a_done});
        end
    endtask

    task automatic test_clean();
        start_run("clean");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({a_busy, a_done, a_tpg_reset, a_fil_reset} !== 4'b1000) begin
            errors++; $display("FAIL clean_start_ignored: got busy/done/tpg/fil=%b, expected 1000",
                               {a_busy, a_done, a_tpg_reset, a_fil_reset});
        end
        for (int i = 0; i < 3; i++) adv_step(1'b1, 1'b0, "clean");
        ev(1'b0, 1'b0, 1'b1);
        checks++;
        if ({a_done, a_busy, a_pass, a_fil_inc, a_tpg_reset, a_aborted} !== 6'b101010 ||
            a_err !== 8'd0 || a_set !== 4'd3) begin
            errors++; $display("FAIL clean_done: got done/busy/pass/inc/tpg/ab=%b err=%0d set=%0d, expected 101010 0 3",
                               {a_done, a_busy, a_pass, a_fil_inc, a_tpg_reset, a_aborted}, a_err, a_set);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (a_done !== 1'b1 || a_pass !== 1'b1 || a_set !== 4'd3) begin
            errors++; $display("FAIL clean_hold: got done=%b pass=%b set=%0d, expected 1 1 3", a_done, a_pass, a_set);
        end
    endtask

    task automatic test_fails();
        start_run("fails");
        adv_step(1'b1, 1'b0, "fails_s0");
        adv_step(1'b1, 1'b0, "fails_s1");
        adv_step(1'b0, 1'b1, "fails_s2");
        checks++;
        if (a_fail_seen !== 1'b1 || a_ffs !== 4'd2 || a_err !== 8'd1 || a_set !== 4'd3) begin
            errors++; $display("FAIL fails_first: got seen=%b ffs=%0d err=%0d set=%0d, expected 1 2 1 3",
                               a_fail_seen, a_ffs, a_err, a_set);
        end
        adv_step(1'b1, 1'b0, "fails_s3");
        adv_step(1'b1, 1'b0, "fails_s4");
        adv_step(1'b0, 1'b1, "fails_s5");
        ev(1'b0, 1'b0, 1'b1);
        checks++;
        if (a_done !== 1'b1 || a_pass !== 1'b0 || a_err !== 8'd2 || a_ffs !== 4'd2 ||
            a_fail_seen !== 1'b1 || a_set !== 4'd6 || a_aborted !== 1'b0) begin
            errors++; $display("FAIL fails_done: got done=%b pass=%b err=%0d ffs=%0d seen=%b set=%0d ab=%b, expected 1 0 2 2 1 6 0",
                               a_done, a_pass, a_err, a_ffs, a_fail_seen, a_set, a_aborted);
        end
    endtask

    task automatic test_back_to_back();
        start_run("b2b");
        ev(1'b1, 1'b0, 1'b0);
        tpg_end = 1'b1;
        @(negedge clk);
        tpg_end = 1'b0;
        checks++;
        if (a_fil_inc !== 1'b0 || a_set !== 4'd1 || a_busy !== 1'b1) begin
            errors++; $display("FAIL b2b_adv_ignores: got fil_inc=%b set=%0d busy=%b, expected 0 1 1", a_fil_inc, a_set, a_busy);
        end
        ev(1'b1, 1'b1, 1'b0);
        checks++;
        if (a_fil_inc !== 1'b1 || a_tpg_reset !== 1'b1 || a_err !== 8'd1 || a_set !== 4'd2 || a_ffs !== 4'd1) begin
            errors++; $display("FAIL b2b_fail_and_end: got inc=%b tpg=%b err=%0d set=%0d ffs=%0d, expected 1 1 1 2 1",
                               a_fil_inc, a_tpg_reset, a_err, a_set, a_ffs);
        end
        @(negedge clk);
        checks++;
        if (a_fil_inc !== 1'b0 || a_err !== 8'd1) begin
            errors++; $display("FAIL b2b_single_pulse: got fil_inc=%b err=%0d, expected 0 1", a_fil_inc, a_err);
        end
        ev(1'b0, 1'b1, 1'b1);
        checks++;
        if (a_done !== 1'b1 || a_fil_inc !== 1'b0 || a_err !== 8'd2 || a_set !== 4'd2 ||
            a_pass !== 1'b0 || a_tpg_reset !== 1'b1 || a_aborted !== 1'b0) begin
            errors++; $display("FAIL b2b_end_with_fail: got done=%b inc=%b err=%0d set=%0d pass=%b tpg=%b ab=%b, expected 1 0 2 2 0 1 0",
                               a_done, a_fil_inc, a_err, a_set, a_pass, a_tpg_reset, a_aborted);
        end
    endtask

    task automatic test_limit();
        start_run("limit");
        for (int i = 0; i < 2; i++) begin
            ev(1'b0, 1'b1, 1'b0);
            checks++;
            if (b_fil_inc !== 1'b1 || b_done !== 1'b0) begin
                errors++; $display("FAIL limit_fail%0d: got b fil_inc=%b done=%b, expected 1 0", i, b_fil_inc, b_done);
            end
            @(negedge clk);
        end
        ev(1'b0, 1'b1, 1'b0);
        checks++;
        if (b_done !== 1'b1 || b_aborted !== 1'b1 || b_err !== 8'd3 || b_fil_inc !== 1'b0 ||
            b_set !== 4'd2 || b_pass !== 1'b0 || b_busy !== 1'b0) begin
            errors++; $display("FAIL limit_abort: got done=%b ab=%b err=%0d inc=%b set=%0d pass=%b busy=%b, expected 1 1 3 0 2 0 0",
                               b_done, b_aborted, b_err, b_fil_inc, b_set, b_pass, b_busy);
        end
        checks++;
        if (c_err !== 2'd3 || c_fil_inc !== 1'b1) begin
            errors++; $display("FAIL sat_three: got c err=%0d fil_inc=%b, expected 3 1", c_err, c_fil_inc);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            ev(1'b0, 1'b1, 1'b0);
            @(negedge clk);
        end
        ev(1'b0, 1'b0, 1'b1);
        checks++;
        if (c_err !== 2'd3 || c_done !== 1'b1 || c_aborted !== 1'b0 || c_set !== 4'd5) begin
            errors++; $display("FAIL sat_hold: got c err=%0d done=%b ab=%b set=%0d, expected 3 1 0 5",
                               c_err, c_done, c_aborted, c_set);
        end
        checks++;
        if (a_err !== 8'd5 || a_aborted !== 1'b0 || a_done !== 1'b1) begin
            errors++; $display("FAIL nolimit_count: got a err=%0d ab=%b done=%b, expected 5 0 1", a_err, a_aborted, a_done);
        end
        checks++;
        if (b_err !== 8'd3 || b_set !== 4'd2 || b_aborted !== 1'b1) begin
            errors++; $display("FAIL limit_stable: got b err=%0d set=%0d ab=%b, expected 3 2 1", b_err, b_set, b_aborted);
        end
    endtask

    task automatic test_reset_mid_adv();
        start_run("rst");
        ev(1'b1, 1'b0, 1'b0);
        checks++;
        if (a_fil_inc !== 1'b1 || a_set !== 4'd1) begin
            errors++; $display("FAIL rst_pre_adv: got fil_inc=%b set=%0d, expected 1 1", a_fil_inc, a_set);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_tpg_reset, a_fil_reset, a_fil_inc, a_busy, a_done, a_pass, a_aborted, a_fail_seen} !== 8'b1100_0000 ||
            a_set !== 4'd0 || a_err !== 8'd0) begin
            errors++; $display("FAIL rst_async: got ctl=%b set=%0d err=%0d, expected 11000000 0 0",
                               {a_tpg_reset, a_fil_reset, a_fil_inc, a_busy, a_done, a_pass, a_aborted, a_fail_seen},
                               a_set, a_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_run("rst_restart");
        adv_step(1'b1, 1'b0, "rst_restart");
        checks++;
        if (a_set !== 4'd1) begin
            errors++; $display("FAIL rst_restart_set: got set=%0d, expected 1", a_set);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_fails();
        test_back_to_back();
        test_limit();
        test_reset_mid_adv();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
